test_unit_sequencer: RTL

TEST_UNIT_SEQUENCER -- requirements
Module: test_unit_sequencer

---
 rtl/test_unit_sequencer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/test_unit_sequencer.sv
// test_unit_sequencer: launches NUM_UNITS test units one at a time and gathers per-unit verdicts.
// Define TEST_UNIT_TIMEOUT_EN to add a per-unit watchdog of TIMEOUT_CYCLES WAIT cycles.
module test_unit_sequencer #(
    parameter int  NUM_UNITS      = 4,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int CUR_W          = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                 clock_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    output logic [NUM_UNITS-1:0] unit_start_o,
    input  logic [NUM_UNITS-1:0] unit_done_i,
    input  logic [NUM_UNITS-1:0] unit_pass_i,
    output logic                 busy_o,
    output logic [CUR_W-1:0]     cur_unit_o,
    output logic [NUM_UNITS-1:0] pass_mask_o,
    output logic [NUM_UNITS-1:0] fail_mask_o,
    output logic [NUM_UNITS-1:0] timeout_mask_o,
    output logic                 all_done_o,
    output logic                 all_pass_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_UNITS-1:0] unit_start_q, unit_start_d;
    logic                 busy_q, busy_d;
    logic [CUR_W-1:0]     cur_unit_q, cur_unit_d;
    logic [NUM_UNITS-1:0] pass_mask_q, pass_mask_d;
    logic [NUM_UNITS-1:0] fail_mask_q, fail_mask_d;
    logic                 all_done_q, all_done_d;
    logic                 all_pass_q, all_pass_d;
    logic                 done_hit_s;
    logic                 last_unit_s;

    // Only the active unit's strobe is ever looked at.
    assign done_hit_s  = unit_done_i[cur_unit_q];
    assign last_unit_s = (cur_unit_q == CUR_W'(NUM_UNITS - 1));

`ifdef TEST_UNIT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic [NUM_UNITS-1:0] timeout_mask_q, timeout_mask_d;
    logic                 timeout_hit_s;

    // wdog_q holds the number of completed WAIT cycles, so this fires in WAIT cycle TIMEOUT_CYCLES.
    assign timeout_hit_s = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // State register.
    always_ff @(posedge clock_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_hit_s) begin
                    state_d = ST_GAP;
                end
`ifdef TEST_UNIT_TIMEOUT_EN
                else if (timeout_hit_s) begin
                    state_d = ST_GAP;
                end
`endif
                else begin
                    state_d = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (last_unit_s) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and result masks.
    always_comb begin
        unit_start_d = unit_start_q;
        busy_d       = busy_q;
        cur_unit_d   = cur_unit_q;
        pass_mask_d  = pass_mask_q;
        fail_mask_d  = fail_mask_q;
        all_done_d   = 1'b0;
        all_pass_d   = all_pass_q;
`ifdef TEST_UNIT_TIMEOUT_EN
        wdog_d         = wdog_q;
        timeout_mask_d = timeout_mask_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pass_mask_d = {NUM_UNITS{1'b0}};
                    fail_mask_d = {NUM_UNITS{1'b0}};
                    all_pass_d  = 1'b0;
                    cur_unit_d  = {CUR_W{1'b0}};
`ifdef TEST_UNIT_TIMEOUT_EN
                    timeout_mask_d = {NUM_UNITS{1'b0}};
`endif
                end else begin
                    all_pass_d = all_pass_q;
                end
            end
            ST_LAUNCH: begin
                unit_start_d             = {NUM_UNITS{1'b0}};
                unit_start_d[cur_unit_q] = 1'b1;
                busy_d                   = 1'b1;
`ifdef TEST_UNIT_TIMEOUT_EN
                wdog_d = {WD_W{1'b0}};
`endif
            end
            ST_WAIT: begin
                // A done in the final watchdog cycle still counts as a real verdict.
                if (done_hit_s) begin
                    pass_mask_d[cur_unit_q] = unit_pass_i[cur_unit_q];
                    fail_mask_d[cur_unit_q] = ~unit_pass_i[cur_unit_q];
                    unit_start_d            = {NUM_UNITS{1'b0}};
                end
`ifdef TEST_UNIT_TIMEOUT_EN
                else if (timeout_hit_s) begin
                    pass_mask_d[cur_unit_q]    = 1'b0;
                    fail_mask_d[cur_unit_q]    = 1'b1;
                    timeout_mask_d[cur_unit_q] = 1'b1;
                    unit_start_d               = {NUM_UNITS{1'b0}};
                end else begin
                    wdog_d = wdog_q + WD_W'(1'b1);
                end
`else
                else begin
                    unit_start_d = unit_start_q;
                end
`endif
            end
            ST_GAP: begin
                if (last_unit_s) begin
                    all_done_d = 1'b1;
                    all_pass_d = ~|fail_mask_q;
                end else begin
                    cur_unit_d = cur_unit_q + CUR_W'(1'b1);
                end
            end
            ST_FINISH: begin
                busy_d = 1'b0;
            end
            default: begin
                unit_start_d = {NUM_UNITS{1'b0}};
                busy_d       = 1'b0;
            end
        endcase
    end

    // Output and result registers.
    always_ff @(posedge clock_i) begin
        if (!rst_n_i) begin
            unit_start_q <= {NUM_UNITS{1'b0}};
            busy_q       <= 1'b0;
            cur_unit_q   <= {CUR_W{1'b0}};
            pass_mask_q  <= {NUM_UNITS{1'b0}};
            fail_mask_q  <= {NUM_UNITS{1'b0}};
            all_done_q   <= 1'b0;
            all_pass_q   <= 1'b0;
        end else begin
            unit_start_q <= unit_start_d;
            busy_q       <= busy_d;
            cur_unit_q   <= cur_unit_d;
            pass_mask_q  <= pass_mask_d;
            fail_mask_q  <= fail_mask_d;
            all_done_q   <= all_done_d;
            all_pass_q   <= all_pass_d;
        end
    end

`ifdef TEST_UNIT_TIMEOUT_EN
    // Watchdog counter and timeout verdicts.
    always_ff @(posedge clock_i) begin
        if (!rst_n_i) begin
            wdog_q         <= {WD_W{1'b0}};
            timeout_mask_q <= {NUM_UNITS{1'b0}};
        end else begin
            wdog_q         <= wdog_d;
            timeout_mask_q <= timeout_mask_d;
        end
    end

    assign timeout_mask_o = timeout_mask_q;
`else
    assign timeout_mask_o = {NUM_UNITS{1'b0}};
`endif

    assign unit_start_o = unit_start_q;
    assign busy_o       = busy_q;
    assign cur_unit_o   = cur_unit_q;
    assign pass_mask_o  = pass_mask_q;
    assign fail_mask_o  = fail_mask_q;
    assign all_done_o   = all_done_q;
    assign all_pass_o   = all_pass_q;

endmodule
